// File: rtl/bloom_filter_ctrl.sv
// Counting bloom filter controller: two hashed counters per packet held in an
// external single-port SRAM; inserts increment them, ACKs test and decrement them.
module bloom_filter_ctrl #(
    parameter int unsigned HASH_BITS     = 19,
    parameter int unsigned CNT_WIDTH     = 36,
    parameter int unsigned INIT_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bloom_wr,
    output logic                 bloom_rdy,
    input  logic [HASH_BITS-1:0] index_0,
    input  logic [HASH_BITS-1:0] index_1,
    input  logic                 pkt_is_ack,
    output logic                 sram_req,
    output logic                 sram_rd_wr_L,
    output logic [HASH_BITS-1:0] sram_addr,
    output logic [CNT_WIDTH-1:0] sram_wr_data,
    input  logic                 sram_ack,
    input  logic [CNT_WIDTH-1:0] sram_rd_data,
    input  logic                 sram_rd_vld,
    output logic                 lookup_done,
    output logic                 lookup_hit,
    output logic [31:0]          num_inserts,
    output logic [31:0]          num_hits,
    output logic [31:0]          num_misses,
    output logic [31:0]          num_saturated
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [HASH_BITS-1:0] ADDR_LAST = '1;

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_RD0,
        S_WAIT0,
        S_RD1,
        S_WAIT1,
        S_DECIDE,
        S_WR0,
        S_WR1
    } state_t;

    localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? S_INIT : S_IDLE;

    state_t               state;
    logic [HASH_BITS-1:0] idx0;
    logic [HASH_BITS-1:0] idx1;
    logic                 is_ack;
    logic [CNT_WIDTH-1:0] cnt0;
    logic [CNT_WIDTH-1:0] cnt1;

    logic                 same_idx;
    logic                 sat0;
    logic                 sat1;
    logic                 hit;
    logic [1:0]           sat_cnt;
    logic [CNT_WIDTH-1:0] upd0;
    logic [CNT_WIDTH-1:0] upd1;

    // Updated counter values; saturated counters are sticky in both directions.
    always_comb begin
        same_idx = (idx0 == idx1);
        sat0     = (cnt0 == CNT_MAX);
        sat1     = (cnt1 == CNT_MAX);
        hit      = (cnt0 != '0) && (cnt1 != '0);
        sat_cnt  = 2'(sat0) + 2'(sat1 && !same_idx);
        upd0     = cnt0;
        upd1     = cnt1;
        if (!is_ack) begin
            if (!sat0) upd0 = cnt0 + CNT_WIDTH'(1);
            if (!sat1) upd1 = cnt1 + CNT_WIDTH'(1);
        end else begin
            if (!sat0) upd0 = cnt0 - CNT_WIDTH'(1);
            if (!sat1) upd1 = cnt1 - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RESET_STATE;
            bloom_rdy     <= 1'b0;
            sram_req      <= 1'b0;
            sram_rd_wr_L  <= 1'b0;
            sram_addr     <= '0;
            sram_wr_data  <= '0;
            lookup_done   <= 1'b0;
            lookup_hit    <= 1'b0;
            num_inserts   <= '0;
            num_hits      <= '0;
            num_misses    <= '0;
            num_saturated <= '0;
            idx0          <= '0;
            idx1          <= '0;
            is_ack        <= 1'b0;
            cnt0          <= '0;
            cnt1          <= '0;
        end else begin
            lookup_done <= 1'b0;
            lookup_hit  <= 1'b0;
            case (state)
                // Zero every word in address order; sram_addr doubles as the sweep pointer.
                S_INIT: begin
                    if (!sram_req) begin
                        sram_req     <= 1'b1;
                        sram_rd_wr_L <= 1'b0;
                        sram_wr_data <= '0;
                    end else if (sram_ack) begin
                        if (sram_addr == ADDR_LAST) begin
                            sram_req  <= 1'b0;
                            bloom_rdy <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            sram_addr <= sram_addr + HASH_BITS'(1);
                        end
                    end
                end
                S_IDLE: begin
                    bloom_rdy <= 1'b1;
                    if (bloom_rdy && bloom_wr) begin
                        idx0         <= index_0;
                        idx1         <= index_1;
                        is_ack       <= pkt_is_ack;
                        bloom_rdy    <= 1'b0;
                        sram_req     <= 1'b1;
                        sram_rd_wr_L <= 1'b1;
                        sram_addr    <= index_0;
                        state        <= S_RD0;
                    end
                end
                S_RD0: begin
                    if (sram_ack) begin
                        sram_req <= 1'b0;
                        state    <= S_WAIT0;
                    end
                end
                S_WAIT0: begin
                    if (sram_rd_vld) begin
                        cnt0 <= sram_rd_data;
                        if (same_idx) begin
                            cnt1  <= sram_rd_data;
                            state <= S_DECIDE;
                        end else begin
                            sram_req     <= 1'b1;
                            sram_rd_wr_L <= 1'b1;
                            sram_addr    <= idx1;
                            state        <= S_RD1;
                        end
                    end
                end
                S_RD1: begin
                    if (sram_ack) begin
                        sram_req <= 1'b0;
                        state    <= S_WAIT1;
                    end
                end
                S_WAIT1: begin
                    if (sram_rd_vld) begin
                        cnt1  <= sram_rd_data;
                        state <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    if (is_ack && !hit) begin
                        num_misses  <= num_misses + 32'd1;
                        lookup_done <= 1'b1;
                        bloom_rdy   <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        if (is_ack) begin
                            num_hits    <= num_hits + 32'd1;
                            lookup_done <= 1'b1;
                            lookup_hit  <= 1'b1;
                        end else begin
                            num_inserts   <= num_inserts + 32'd1;
                            num_saturated <= num_saturated + 32'(sat_cnt);
                        end
                        cnt1         <= upd1;
                        sram_req     <= 1'b1;
                        sram_rd_wr_L <= 1'b0;
                        sram_addr    <= idx0;
                        sram_wr_data <= upd0;
                        state        <= S_WR0;
                    end
                end
                // A shared index has a single counter, so the second write is skipped.
                S_WR0: begin
                    if (sram_ack) begin
                        if (same_idx) begin
                            sram_req  <= 1'b0;
                            bloom_rdy <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            sram_addr    <= idx1;
                            sram_wr_data <= cnt1;
                            state        <= S_WR1;
                        end
                    end
                end
                S_WR1: begin
                    if (sram_ack) begin
                        sram_req  <= 1'b0;
                        bloom_rdy <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    sram_req <= 1'b0;
                    state    <= RESET_STATE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bloom_filter_ctrl.sv
// Bench for bloom_filter_ctrl: behavioural SRAM with random ack/read latency and
// a word-level counting bloom filter model checked after every request.
module tb_bloom_filter_ctrl;

    localparam int unsigned HB    = 4;
    localparam int unsigned CW    = 8;
    localparam int unsigned WORDS = 16;
    localparam logic [CW-1:0] CMAX = 8'hFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          bloom_wr;
    logic          bloom_rdy;
    logic [HB-1:0] index_0;
    logic [HB-1:0] index_1;
    logic          pkt_is_ack;
    logic          sram_req;
    logic          sram_rd_wr_L;
    logic [HB-1:0] sram_addr;
    logic [CW-1:0] sram_wr_data;
    logic          sram_ack;
    logic [CW-1:0] sram_rd_data;
    logic          sram_rd_vld;
    logic          lookup_done;
    logic          lookup_hit;
    logic [31:0]   num_inserts;
    logic [31:0]   num_hits;
    logic [31:0]   num_misses;
    logic [31:0]   num_saturated;

    always #5 clk = ~clk;

    bloom_filter_ctrl #(
        .HASH_BITS    (HB),
        .CNT_WIDTH    (CW),
        .INIT_ON_RESET(1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bloom_wr     (bloom_wr),
        .bloom_rdy    (bloom_rdy),
        .index_0      (index_0),
        .index_1      (index_1),
        .pkt_is_ack   (pkt_is_ack),
        .sram_req     (sram_req),
        .sram_rd_wr_L (sram_rd_wr_L),
        .sram_addr    (sram_addr),
        .sram_wr_data (sram_wr_data),
        .sram_ack     (sram_ack),
        .sram_rd_data (sram_rd_data),
        .sram_rd_vld  (sram_rd_vld),
        .lookup_done  (lookup_done),
        .lookup_hit   (lookup_hit),
        .num_inserts  (num_inserts),
        .num_hits     (num_hits),
        .num_misses   (num_misses),
        .num_saturated(num_saturated)
    );

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] sram_mem [WORDS];
    logic [CW-1:0] ref_mem  [WORDS];
    logic [31:0]   ref_inserts, ref_hits, ref_misses, ref_sat;

    int ack_dly_fix = 0;
    int rd_lat_fix  = -1;
    int rd_cnt = 0;
    int wr_cnt = 0;
    bit in_init = 1'b1;
    int init_idx = 0;
    bit chk_rdy_next = 1'b0;
    bit lk_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SRAM: random ack delay 0..2, read data 1..3 cycles after ack, init-sweep checking.
    initial begin : sram_model
        bit              busy;
        int              dly;
        int              rd_wait;
        logic [CW-1:0]   rd_val;
        logic [HB+CW:0]  op_sig;
        busy = 1'b0; dly = 0; rd_wait = 0; rd_val = '0; op_sig = '0;
        sram_ack = 1'b0; sram_rd_vld = 1'b0; sram_rd_data = '0;
        forever begin
            @(negedge clk);
            sram_ack    = 1'b0;
            sram_rd_vld = 1'b0;
            if (lookup_done === 1'b1) lk_q.push_back(lookup_hit);
            if (chk_rdy_next) begin
                check_eq("rdy_after_init", 64'(bloom_rdy), 64'(1));
                chk_rdy_next = 1'b0;
            end
            if (rd_wait > 0) begin
                rd_wait--;
                if (rd_wait == 0) begin
                    sram_rd_vld  = 1'b1;
                    sram_rd_data = rd_val;
                end
            end
            if (reset) begin
                busy = 1'b0;
            end else if (sram_req) begin
                if (!busy) begin
                    dly    = (ack_dly_fix >= 0) ? ack_dly_fix : int'($urandom_range(0, 2));
                    op_sig = {sram_rd_wr_L, sram_addr, sram_wr_data};
                    busy   = 1'b1;
                end else begin
                    check_eq("sram_stable", 64'({sram_rd_wr_L, sram_addr, sram_wr_data}), 64'(op_sig));
                end
                if (dly == 0) begin
                    busy     = 1'b0;
                    sram_ack = 1'b1;
                    if (sram_rd_wr_L) begin
                        rd_cnt++;
                        rd_val  = sram_mem[sram_addr];
                        rd_wait = (rd_lat_fix > 0) ? rd_lat_fix : int'($urandom_range(1, 3));
                    end else begin
                        wr_cnt++;
                        sram_mem[sram_addr] = sram_wr_data;
                        if (in_init) begin
                            check_eq("init_addr", 64'(sram_addr), 64'(init_idx));
                            check_eq("init_data", 64'(sram_wr_data), 64'(0));
                            init_idx++;
                            if (init_idx == int'(WORDS)) begin
                                in_init = 1'b0;
                                check_eq("rdy_at_last_ack", 64'(bloom_rdy), 64'(0));
                                chk_rdy_next = 1'b1;
                            end
                        end
                    end
                end else begin
                    dly--;
                end
            end
        end
    end

    function automatic void ref_bump(input logic [HB-1:0] a, input bit up);
        if (ref_mem[a] == CMAX) begin
            if (up) ref_sat = ref_sat + 32'd1;
        end else begin
            ref_mem[a] = up ? ref_mem[a] + 8'd1 : ref_mem[a] - 8'd1;
        end
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = '0;
        ref_inserts = '0; ref_hits = '0; ref_misses = '0; ref_sat = '0;
    endtask

    task automatic preset(input logic [HB-1:0] a, input logic [CW-1:0] v);
        sram_mem[a] = v;
        ref_mem[a]  = v;
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (bloom_rdy !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq(tag, 64'(bloom_rdy), 64'(1));
    endtask

    task automatic check_stats();
        check_eq("num_inserts", 64'(num_inserts), 64'(ref_inserts));
        check_eq("num_hits", 64'(num_hits), 64'(ref_hits));
        check_eq("num_misses", 64'(num_misses), 64'(ref_misses));
        check_eq("num_saturated", 64'(num_saturated), 64'(ref_sat));
    endtask

    // One request plus a stray strobe while busy; then compare against the model.
    task automatic do_op(input logic [HB-1:0] i0, input logic [HB-1:0] i1, input bit ack);
        int rd0, wr0, exp_wr, distinct;
        bit exp_lk, exp_hit;
        wait_rdy("rdy_before_req");
        lk_q.delete();
        rd0 = rd_cnt; wr0 = wr_cnt;
        index_0 = i0; index_1 = i1; pkt_is_ack = ack; bloom_wr = 1'b1;
        @(posedge clk); #1;
        bloom_wr = 1'b0;
        check_eq("rdy_drop", 64'(bloom_rdy), 64'(0));
        pkt_is_ack = ~ack; bloom_wr = 1'b1;
        @(posedge clk); #1;
        bloom_wr = 1'b0;

        distinct = (i0 == i1) ? 1 : 2;
        exp_lk = 1'b0; exp_hit = 1'b0;
        if (!ack) begin
            ref_inserts = ref_inserts + 32'd1;
            ref_bump(i0, 1'b1);
            if (i1 != i0) ref_bump(i1, 1'b1);
            exp_wr = distinct;
        end else if (ref_mem[i0] != 0 && ref_mem[i1] != 0) begin
            ref_hits = ref_hits + 32'd1;
            ref_bump(i0, 1'b0);
            if (i1 != i0) ref_bump(i1, 1'b0);
            exp_wr = distinct; exp_lk = 1'b1; exp_hit = 1'b1;
        end else begin
            ref_misses = ref_misses + 32'd1;
            exp_wr = 0; exp_lk = 1'b1;
        end

        wait_rdy("op_done");
        @(posedge clk); #1;
        check_eq("sram_reads", 64'(rd_cnt - rd0), 64'(distinct));
        check_eq("sram_writes", 64'(wr_cnt - wr0), 64'(exp_wr));
        check_eq("lookup_pulses", 64'(lk_q.size()), 64'(exp_lk ? 1 : 0));
        if (exp_lk && lk_q.size() > 0) check_eq("lookup_hit", 64'(lk_q[0]), 64'(exp_hit));
        check_eq("word_idx0", 64'(sram_mem[i0]), 64'(ref_mem[i0]));
        check_eq("word_idx1", 64'(sram_mem[i1]), 64'(ref_mem[i1]));
        check_stats();
    endtask

    initial begin : main
        int rd0, wr0, n;
        reset = 1'b1; bloom_wr = 1'b0; index_0 = '0; index_1 = '0; pkt_is_ack = 1'b0;
        for (int i = 0; i < int'(WORDS); i++) sram_mem[i] = CW'($urandom);
        ref_clear();

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rdy", 64'(bloom_rdy), 64'(0));
        check_eq("rst_req", 64'(sram_req), 64'(0));
        check_eq("rst_lookup_done", 64'(lookup_done), 64'(0));
        check_stats();
        reset = 1'b0;
        wait_rdy("init_done");
        check_eq("init_writes", 64'(wr_cnt), 64'(16));
        check_eq("init_reads", 64'(rd_cnt), 64'(0));

        // Directed cases
        ack_dly_fix = -1;
        do_op(4'd3, 4'd9, 1'b0);
        do_op(4'd3, 4'd9, 1'b1);
        check_eq("w3_back_to_0", 64'(sram_mem[3]), 64'(0));
        preset(4'd5, 8'd2); preset(4'd6, 8'd0);
        do_op(4'd5, 4'd6, 1'b1);
        check_eq("w5_kept", 64'(sram_mem[5]), 64'(2));
        do_op(4'd7, 4'd7, 1'b0);
        do_op(4'd7, 4'd7, 1'b0);
        check_eq("w7_final", 64'(sram_mem[7]), 64'(2));
        preset(4'd4, CMAX);
        do_op(4'd4, 4'd8, 1'b0);
        check_eq("w4_sticky", 64'(sram_mem[4]), 64'(CMAX));
        check_eq("sat_one", 64'(num_saturated), 64'(1));
        do_op(4'd4, 4'd8, 1'b1);
        check_eq("w4_no_dec", 64'(sram_mem[4]), 64'(CMAX));

        // Random traffic over a narrow index range to get plenty of hits
        for (int t = 0; t < 70; t++) begin
            if ($urandom_range(0, 11) == 0) preset(HB'($urandom_range(0, 5)), CMAX);
            do_op(HB'($urandom_range(0, 5)), HB'($urandom_range(0, 5)), $urandom_range(0, 9) < 4);
        end

        // Reset while waiting for read data; stale rd_vld lands during the new sweep
        ack_dly_fix = 0; rd_lat_fix = 3;
        wait_rdy("rdy_before_abort");
        rd0 = rd_cnt;
        index_0 = 4'd2; index_1 = 4'd11; pkt_is_ack = 1'b0; bloom_wr = 1'b1;
        @(posedge clk); #1;
        bloom_wr = 1'b0;
        n = 0;
        while (rd_cnt == rd0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("abort_read_issued", 64'(rd_cnt), 64'(rd0 + 1));
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_req_low", 64'(sram_req), 64'(0));
        check_eq("abort_rdy_low", 64'(bloom_rdy), 64'(0));
        ref_clear();
        check_stats();
        in_init = 1'b1; init_idx = 0;
        wr0 = wr_cnt;
        reset = 1'b0;
        bloom_wr = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        bloom_wr = 1'b0;
        rd_lat_fix = -1;
        wait_rdy("reinit_done");
        check_eq("reinit_writes", 64'(wr_cnt - wr0), 64'(16));
        check_stats();
        for (int i = 0; i < int'(WORDS); i++) sram_mem[i] = sram_mem[i];

        ack_dly_fix = -1;
        do_op(4'd2, 4'd11, 1'b1);
        do_op(4'd2, 4'd11, 1'b0);
        for (int t = 0; t < 20; t++)
            do_op(HB'($urandom_range(0, 4)), HB'($urandom_range(0, 4)), $urandom_range(0, 1) == 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
